index_merge_feeder: RTL

//  Upstream feeder for the parallel-indices compare/FIFO stage. Accepts two

---
 rtl/index_merge_feeder.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/index_merge_feeder.sv
`default_nettype none
// ============================================================================
// Module   : index_merge_feeder
// Purpose  : Merge-intersect walker feeding the parallel-indices compare stage.
//            Two ascending sparse-index streams (row of A, column of B) are
//            accepted over valid/ready handshakes into one-entry head
//            registers. Each cycle the heads are compared:
//              equal -> one registered write of the index, consume both heads
//              less  -> consume the smaller head only
//            When one stream ends, the other is drained to its last element
//            with no writes, so the upstream readers always complete.
// Ports    : clk, rst_n           clock / asynchronous active-low reset
//            start                begin a new vector pair (taken in IDLE only)
//            a_valid/a_ready/a_idx/a_last   stream A handshake and payload
//            b_valid/b_ready/b_idx/b_last   stream B handshake and payload
//            stall                downstream cannot take a write
//            A0, B0, write        registered write to the compare stage
//            match_cnt            matches emitted in the current vector
//            busy, done           vector in progress / completion pulse
// Revision : 1.0  initial release
// ============================================================================
module index_merge_feeder #(
    parameter int IDX_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [IDX_W-1:0] a_idx,
    input  logic             a_last,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [IDX_W-1:0] b_idx,
    input  logic             b_last,
    input  logic             stall,
    output logic [IDX_W-1:0] A0,
    output logic [IDX_W-1:0] B0,
    output logic             write,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RUN     = 3'd1;
    localparam logic [2:0] c_DRAIN_A = 3'd2;
    localparam logic [2:0] c_DRAIN_B = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;

    // Head registers: one buffered element per stream.
    logic [IDX_W-1:0] r_ha_idx;
    logic             r_ha_last;
    logic             r_ha_vld;
    logic [IDX_W-1:0] r_hb_idx;
    logic             r_hb_last;
    logic             r_hb_vld;

    // Set once the last element of a stream has been accepted into its head.
    // Blocks further acceptance so elements of the following vector are never
    // pulled in early.
    logic             r_a_got_last;
    logic             r_b_got_last;

    logic [IDX_W-1:0] r_a0;
    logic [IDX_W-1:0] r_b0;
    logic             r_write;
    logic [CNT_W-1:0] r_match_cnt;
    logic             r_busy;
    logic             r_done;

    logic             w_start_acc;
    logic             w_run;
    logic             w_drain_a;
    logic             w_drain_b;
    logic             w_cmp_ok;
    logic             w_eq;
    logic             w_lt;
    logic             w_match;
    logic             w_cons_a;
    logic             w_cons_b;
    logic             w_end_a;
    logic             w_end_b;
    logic             w_acc_a;
    logic             w_acc_b;

    // ------------------------------------------------------------------------
    // Decision logic
    // ------------------------------------------------------------------------
    assign w_start_acc = (r_state == c_IDLE) && start;
    assign w_run       = (r_state == c_RUN);
    assign w_drain_a   = (r_state == c_DRAIN_A);
    assign w_drain_b   = (r_state == c_DRAIN_B);

    // A compare decision needs both heads and a downstream able to take a write.
    assign w_cmp_ok = w_run && r_ha_vld && r_hb_vld && !stall;
    assign w_eq     = (r_ha_idx == r_hb_idx);
    assign w_lt     = (r_ha_idx <  r_hb_idx);
    assign w_match  = w_cmp_ok && w_eq;

    // Draining never writes, so it proceeds regardless of stall.
    assign w_cons_a = (w_cmp_ok && (w_eq || w_lt))  || (w_drain_a && r_ha_vld);
    assign w_cons_b = (w_cmp_ok && (w_eq || !w_lt)) || (w_drain_b && r_hb_vld);

    assign w_end_a  = w_cons_a && r_ha_last;
    assign w_end_b  = w_cons_b && r_hb_last;

    // A head may refill in the same cycle it is consumed: 1 element/cycle.
    assign a_ready  = (w_run || w_drain_a) && !r_a_got_last && (!r_ha_vld || w_cons_a);
    assign b_ready  = (w_run || w_drain_b) && !r_b_got_last && (!r_hb_vld || w_cons_b);

    assign w_acc_a  = a_valid && a_ready;
    assign w_acc_b  = b_valid && b_ready;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                if (w_end_a && w_end_b) begin
                    w_state_nxt = c_DONE;
                end else if (w_end_a) begin
                    w_state_nxt = c_DRAIN_B;
                end else if (w_end_b) begin
                    w_state_nxt = c_DRAIN_A;
                end
            end
            c_DRAIN_A: begin
                if (w_end_a) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DRAIN_B: begin
                if (w_end_b) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Head registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ha_idx     <= '0;
            r_ha_last    <= 1'b0;
            r_ha_vld     <= 1'b0;
            r_a_got_last <= 1'b0;
        end else if (w_start_acc) begin
            r_ha_vld     <= 1'b0;
            r_a_got_last <= 1'b0;
        end else if (w_acc_a) begin
            r_ha_idx     <= a_idx;
            r_ha_last    <= a_last;
            r_ha_vld     <= 1'b1;
            r_a_got_last <= a_last;
        end else if (w_cons_a) begin
            r_ha_vld     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hb_idx     <= '0;
            r_hb_last    <= 1'b0;
            r_hb_vld     <= 1'b0;
            r_b_got_last <= 1'b0;
        end else if (w_start_acc) begin
            r_hb_vld     <= 1'b0;
            r_b_got_last <= 1'b0;
        end else if (w_acc_b) begin
            r_hb_idx     <= b_idx;
            r_hb_last    <= b_last;
            r_hb_vld     <= 1'b1;
            r_b_got_last <= b_last;
        end else if (w_cons_b) begin
            r_hb_vld     <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a0        <= '0;
            r_b0        <= '0;
            r_write     <= 1'b0;
            r_match_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_write <= w_match;
            // A0/B0 only move on a write so the compare stage sees stable data.
            if (w_match) begin
                r_a0 <= r_ha_idx;
                r_b0 <= r_hb_idx;
            end
            if (w_start_acc) begin
                r_match_cnt <= '0;
            end else if (w_match) begin
                r_match_cnt <= r_match_cnt + CNT_W'(1);
            end
            r_busy <= (w_state_nxt == c_RUN) || (w_state_nxt == c_DRAIN_A) ||
                      (w_state_nxt == c_DRAIN_B);
            r_done <= (w_state_nxt == c_DONE);
        end
    end

    assign A0        = r_a0;
    assign B0        = r_b0;
    assign write     = r_write;
    assign match_cnt = r_match_cnt;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
